// File: rtl/add3_seq_ctrl_pkg.sv
// Shared types and constants for the chunked add/subtract controller.
//   state_t  : controller FSM states
//   SLICE_W  : width of the shared adder slice (bits per chunk)
//   calc_w() : operand width for a given chunk count
package add3_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 3;

  function automatic int calc_w(input int chunks);
    return SLICE_W * chunks;
  endfunction

endpackage

// File: rtl/add3_seq_ctrl_if.sv
// Operand/result handshake bundle for add3_seq_ctrl.
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   master : producer/consumer side (drives operands, accepts result)
//   slave  : controller side
interface add3_seq_ctrl_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add3_seq_ctrl_slice.sv
// Combinational 3-bit ripple adder built from XOR/NAND full adders.
//   a, b : 3-bit addends      ci : carry in
//   s    : 3-bit sum          co : carry out of bit 2
//   c2   : carry into bit 2 (needed for signed overflow on the top chunk)
module add3_slice
  import add3_seq_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c2
);
  logic [SLICE_W:0]   c;
  logic [SLICE_W-1:0] x;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign x[i]   = a[i] ^ b[i];
    assign s[i]   = x[i] ^ c[i];
    // carry = NAND(NAND(a,b), NAND(a^b, cin))
    assign c[i+1] = ~(~(a[i] & b[i]) & ~(x[i] & c[i]));
  end

  assign co = c[SLICE_W];
  assign c2 = c[SLICE_W-1];
endmodule

// File: rtl/add3_seq_ctrl.sv
// Sequencing controller: multi-word add/subtract through one shared 3-bit
// slice, one chunk per clock, LSB chunk first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of add3_seq_ctrl_if (operand + result handshakes)
// Parameter CHUNKS (2..16) sets the operand width W = 3*CHUNKS.
module add3_seq_ctrl
  import add3_seq_ctrl_pkg::*;
#(
  parameter int CHUNKS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add3_seq_ctrl_if.slave bus
);
  localparam int W  = calc_w(CHUNKS);
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry_r;
  logic [W-1:0]  a_r, b_r, sum_r;
  logic          cout_r, ovf_r;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic               sl_co, sl_c2;

  // b_r already holds ~b for subtract, so the slice only ever adds
  assign sl_a = a_r[SLICE_W*idx +: SLICE_W];
  assign sl_b = b_r[SLICE_W*idx +: SLICE_W];

  add3_slice u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_r),
    .s  (sl_s),
    .co (sl_co),
    .c2 (sl_c2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r     <= bus.a;
          b_r     <= bus.sub ? ~bus.b : bus.b;
          carry_r <= bus.sub | bus.cin;  // subtract = a + ~b + 1
          idx     <= '0;
          state   <= RUN;
        end
        RUN: begin
          sum_r[SLICE_W*idx +: SLICE_W] <= sl_s;
          carry_r <= sl_co;
          if (idx == LAST) begin
            cout_r <= sl_co;
            ovf_r  <= sl_c2 ^ sl_co;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // handshake outputs depend on state only
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule
